// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- multicycle-datapath program counter with ALU output register,
//            retired-fetch counter, sticky misalignment flag and optional
//            branch statistics.
//
// Parameters:
//   RESET_PC   PC value loaded while rst is low
//   CNT_W      width of the branch statistics counters
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-low reset
//   PCWrite      unconditional PC load
//   PCWriteCond  conditional (branch) PC load
//   PCCondSrc    branch sense: 1 = beq (take on Zero), 0 = bne (take on !Zero)
//   PCSource     next-PC select: 00 ALUResult, 01 ALUOut, 10 jump, 11 hold
//   Zero         ALU zero flag
//   ALUResult    combinational ALU result
//   IRJump       instruction register bits [25:0]
//   PC           current program counter
//   ALUOut       ALUResult delayed by one cycle
//   InstrCount   number of fetch increments (PCWrite with PCSource=00)
//   AlignErr     sticky flag: a loaded target had non-zero bits [1:0]
//   BrTaken      saturating count of taken branches
//   BrNotTaken   saturating count of not-taken branches
//
// Build option:
//   PC_UNIT_BRANCH_STATS_EN  when defined, BrTaken/BrNotTaken are live
//                            saturating counters; otherwise they are tied
//                            to zero and no counter state exists.
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWrite,
    input  logic             PCWriteCond,
    input  logic             PCCondSrc,
    input  logic [1:0]       PCSource,
    input  logic             Zero,
    input  logic [31:0]      ALUResult,
    input  logic [25:0]      IRJump,
    output logic [31:0]      PC,
    output logic [31:0]      ALUOut,
    output logic [31:0]      InstrCount,
    output logic             AlignErr,
    output logic [CNT_W-1:0] BrTaken,
    output logic [CNT_W-1:0] BrNotTaken
);

    logic [31:0] pc_reg, pc_next;
    logic [31:0] alu_out_reg;
    logic [31:0] instr_count_reg;
    logic        align_err_reg, align_err_next;

    logic        cond;
    logic        load_en;
    logic        sel_hold;
    logic [31:0] target;
    logic        fetch_inc;
    logic        branch_only;

    always_comb begin
        cond        = PCCondSrc ? Zero : ~Zero;
        load_en     = PCWrite | (PCWriteCond & cond);
        sel_hold    = (PCSource == 2'b11);
        fetch_inc   = PCWrite & (PCSource == 2'b00);
        // A branch is only an event for the statistics when the unconditional
        // load is not also asserted and a real target is selected.
        branch_only = PCWriteCond & ~PCWrite & ~sel_hold;

        target = pc_reg;
        case (PCSource)
            2'b00:   target = ALUResult;
            2'b01:   target = alu_out_reg;
            2'b10:   target = {pc_reg[31:28], IRJump, 2'b00};
            default: target = pc_reg;
        endcase

        pc_next        = pc_reg;
        align_err_next = align_err_reg;
        // Hold select never rewrites PC, so it can never raise AlignErr.
        if (load_en && !sel_hold) begin
            pc_next = {target[31:2], 2'b00};
            if (target[1:0] != 2'b00) begin
                align_err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            alu_out_reg     <= 32'h0000_0000;
            instr_count_reg <= 32'h0000_0000;
            align_err_reg   <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            alu_out_reg   <= ALUResult;
            align_err_reg <= align_err_next;
            if (fetch_inc) begin
                instr_count_reg <= instr_count_reg + 32'd1;
            end
        end
    end

    assign PC         = pc_reg;
    assign ALUOut     = alu_out_reg;
    assign InstrCount = instr_count_reg;
    assign AlignErr   = align_err_reg;

`ifdef PC_UNIT_BRANCH_STATS_EN
    logic [CNT_W-1:0] br_taken_reg;
    logic [CNT_W-1:0] br_not_taken_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            br_taken_reg     <= '0;
            br_not_taken_reg <= '0;
        end else if (branch_only) begin
            // Counters stick at all-ones instead of wrapping.
            if (cond && (br_taken_reg != {CNT_W{1'b1}})) begin
                br_taken_reg <= br_taken_reg + 1'b1;
            end
            if (!cond && (br_not_taken_reg != {CNT_W{1'b1}})) begin
                br_not_taken_reg <= br_not_taken_reg + 1'b1;
            end
        end
    end

    assign BrTaken    = br_taken_reg;
    assign BrNotTaken = br_not_taken_reg;
`else
    logic unused_stats;
    assign unused_stats = branch_only;
    assign BrTaken      = '0;
    assign BrNotTaken   = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- self-checking bench for pc_unit. A behavioural model is
// stepped once per rising edge from the stimulus task; a compare process
// checks every output against it on each falling edge, and directed
// literal checks pin the model at the key points.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    localparam int CNT_W = 16;
`ifdef PC_UNIT_BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             PCWrite, PCWriteCond, PCCondSrc, Zero;
    logic [1:0]       PCSource;
    logic [31:0]      ALUResult;
    logic [25:0]      IRJump;
    logic [31:0]      PC, ALUOut, InstrCount;
    logic             AlignErr;
    logic [CNT_W-1:0] BrTaken, BrNotTaken;

    pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCCondSrc(PCCondSrc), .PCSource(PCSource), .Zero(Zero),
        .ALUResult(ALUResult), .IRJump(IRJump), .PC(PC), .ALUOut(ALUOut),
        .InstrCount(InstrCount), .AlignErr(AlignErr), .BrTaken(BrTaken),
        .BrNotTaken(BrNotTaken)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    longint m_pc, m_alu, m_ic, m_bt, m_bnt;
    bit     m_ae;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one rising edge, using the inputs held over it.
    task automatic model_edge();
        longint tgt;
        bit     c;
        if (!rst) begin
            m_pc = 0; m_alu = 0; m_ic = 0; m_ae = 0; m_bt = 0; m_bnt = 0;
            return;
        end
        c = PCCondSrc ? Zero : !Zero;
        case (PCSource)
            2'd0: tgt = ALUResult;
            2'd1: tgt = m_alu;
            2'd2: tgt = (m_pc / 268435456) * 268435456 + longint'(IRJump) * 4;
            default: tgt = m_pc;
        endcase
        if ((PCWrite || (PCWriteCond && c)) && PCSource != 2'd3) begin
            if (tgt % 4 != 0) m_ae = 1;
            m_pc = tgt - (tgt % 4);
        end
        if (PCWrite && PCSource == 2'd0) m_ic = (m_ic + 1) % 64'h1_0000_0000;
        if (STATS && PCWriteCond && !PCWrite && PCSource != 2'd3) begin
            if (c) m_bt  = (m_bt  < CNT_MAX) ? m_bt  + 1 : CNT_MAX;
            else   m_bnt = (m_bnt < CNT_MAX) ? m_bnt + 1 : CNT_MAX;
        end
        m_alu = ALUResult;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic idle();
        PCWrite = 0; PCWriteCond = 0; PCCondSrc = 0; Zero = 0;
        PCSource = 2'd3; ALUResult = 0; IRJump = 0;
    endtask

    task automatic drive(input bit w, input bit wc, input bit cs, input bit z,
                         input logic [1:0] src, input logic [31:0] alu);
        PCWrite = w; PCWriteCond = wc; PCCondSrc = cs; Zero = z;
        PCSource = src; ALUResult = alu;
    endtask

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", PC, m_pc);
            check("aluout", ALUOut, m_alu);
            check("instrcount", InstrCount, m_ic);
            check("alignerr", AlignErr, m_ae);
            check("brtaken", BrTaken, m_bt);
            check("brnottaken", BrNotTaken, m_bnt);
        end
    end

    initial begin
        idle();
        rst = 0;
        // Reset for two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom), $urandom);
            IRJump = 26'($urandom);
            step();
            chk_en = 1'b1;
        end
        idle();
        rst = 1;
        check("rst_pc", PC, 32'h0);
        check("rst_aluout", ALUOut, 32'h0);
        check("rst_ic", InstrCount, 32'h0);
        check("rst_ae", AlignErr, 1'b0);
        check("rst_bt", BrTaken, 0);
        check("rst_bnt", BrNotTaken, 0);
        step();

        // Fetch increment
        drive(1, 0, 0, 0, 2'd0, 32'h0000_0004); step();
        check("fetch_pc", PC, 32'h4);
        check("fetch_ic", InstrCount, 1);
        check("fetch_aluout", ALUOut, 32'h4);

        // beq taken via ALUOut
        drive(0, 0, 0, 0, 2'd3, 32'h0000_0040); step();
        drive(0, 1, 1, 1, 2'd1, 32'h0000_0040); step();
        check("beq_pc", PC, 32'h40);
        check("beq_bt", BrTaken, STATS ? 1 : 0);
        // bne with Zero=1 -> not taken
        drive(0, 1, 0, 1, 2'd1, 32'h0000_0080); step();
        check("bne_nt_pc", PC, 32'h40);
        check("bne_nt_bnt", BrNotTaken, STATS ? 1 : 0);

        // Jump
        drive(1, 0, 0, 0, 2'd0, 32'h1000_0008); step();
        check("pre_jump_pc", PC, 32'h1000_0008);
        drive(1, 0, 0, 0, 2'd2, 32'h0); IRJump = 26'h000_0010; step();
        check("jump_pc", PC, 32'h1000_0040);
        check("jump_ic", InstrCount, 2);

        // Hold select with load
        drive(1, 0, 0, 0, 2'd3, 32'h0000_0123); step();
        check("hold_pc", PC, 32'h1000_0040);
        check("hold_ic", InstrCount, 2);
        check("hold_ae", AlignErr, 0);

        // Misaligned target
        drive(1, 0, 0, 0, 2'd0, 32'h0000_0006); step();
        check("mis_pc", PC, 32'h4);
        check("mis_ae", AlignErr, 1);
        idle();
        for (int i = 0; i < 10; i++) step();
        check("mis_ae_sticky", AlignErr, 1);

        // bne taken
        drive(0, 1, 0, 0, 2'd0, 32'h0000_0100); step();
        check("bne_t_pc", PC, 32'h100);
        check("bne_t_bt", BrTaken, STATS ? 2 : 0);

        // Both loads: unconditional wins, no branch count
        drive(1, 1, 1, 0, 2'd0, 32'h0000_0200); step();
        check("both_pc", PC, 32'h200);
        check("both_ic", InstrCount, 4);
        check("both_bnt", BrNotTaken, STATS ? 1 : 0);

        // InstrCount wrap from preloaded all-ones
        idle();
        force dut.instr_count_reg = 32'hFFFF_FFFF;
        #1 release dut.instr_count_reg;
        m_ic = 64'hFFFF_FFFF;
`ifdef PC_UNIT_BRANCH_STATS_EN
        force dut.br_taken_reg = {CNT_W{1'b1}};
        #1 release dut.br_taken_reg;
        m_bt = CNT_MAX;
`endif
        step();
        check("preload_ic", InstrCount, 32'hFFFF_FFFF);
        drive(1, 0, 0, 0, 2'd0, 32'h0000_0300); step();
        check("wrap_ic", InstrCount, 0);
        drive(0, 1, 1, 1, 2'd0, 32'h0000_0310); step();
        check("sat_bt", BrTaken, STATS ? 16'hFFFF : 0);
        check("sat_pc", PC, 32'h310);

        // Reset during a taken branch: reset values only
        drive(0, 1, 1, 1, 2'd0, 32'h0000_0500);
        rst = 0; step();
        check("midrst_pc", PC, 32'h0);
        check("midrst_bt", BrTaken, 0);
        check("midrst_ae", AlignErr, 0);
        rst = 1;
        drive(1, 0, 0, 0, 2'd0, 32'h0000_0008); step();
        check("resume_pc", PC, 32'h8);
        check("resume_ic", InstrCount, 1);

        idle(); step(); step();
        @(negedge clk); #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #100000;
        $display("FAIL timeout: actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
